cache_mem_arb: RTL and testbench

CACHE_MEM_ARB -- requirements
Module: cache_mem_arb

---
 rtl/cache_mem_arb.sv | 119 +++++++++++
 tb/tb_cache_mem_arb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arb.sv
// cache_mem_arb: lets two requesters share one single-port SRAM.
// After reset, or after a clear pulse, every word of the SRAM is written
// with zero. Once that is done, the SRAM is handed to requesters A and B,
// with round-robin arbitration when both ask in the same cycle.
//
// state | meaning
// INIT  | writing 0 to word cnt_q each cycle; no grants; o_init_busy=1
// RUN   | arbitrating A/B, at most one SRAM access per cycle
module cache_mem_arb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_a_req,
  input  logic              i_a_write,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  input  logic              i_b_req,
  input  logic              i_b_write,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_a_gnt,
  output logic              o_b_gnt,
  output logic              o_a_rvalid,
  output logic              o_b_rvalid,
  output logic [DATA_W-1:0] o_a_rdata,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic              o_mem_enable,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_init_busy
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  // 1 when B wins the next tie, i.e. A was granted most recently
  logic              prio_b_q;
  logic              a_rv_q, b_rv_q;
  logic              gnt_a, gnt_b;

  // Next state, clear counter, arbitration and SRAM port mux
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_a        = 1'b0;
    gnt_b        = 1'b0;
    o_mem_enable = 1'b0;
    o_mem_write  = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_init_busy  = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Clear requests are ignored here. The counter wraps to 0 after
        // the last word, so RUN is entered with the counter already at 0.
        o_init_busy  = 1'b1;
        o_mem_enable = 1'b1;
        o_mem_write  = 1'b1;
        o_mem_addr   = cnt_q;
        cnt_d        = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_a_req && (!i_b_req || !prio_b_q)) gnt_a = 1'b1;
        else if (i_b_req)                       gnt_b = 1'b1;
        if (gnt_a) begin
          o_mem_enable = 1'b1;
          o_mem_write  = i_a_write;
          o_mem_addr   = i_a_addr;
          o_mem_wdata  = i_a_wdata;
        end else if (gnt_b) begin
          o_mem_enable = 1'b1;
          o_mem_write  = i_b_write;
          o_mem_addr   = i_b_addr;
          o_mem_wdata  = i_b_wdata;
        end
        // An access granted in this same cycle still completes. Its
        // read data comes back during the first INIT cycle.
        if (i_clear) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State, counter, round-robin pointer and read-valid pipeline
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      prio_b_q <= 1'b0;
      a_rv_q   <= 1'b0;
      b_rv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (gnt_a)      prio_b_q <= 1'b1;
      else if (gnt_b) prio_b_q <= 1'b0;
      a_rv_q <= gnt_a && !i_a_write;
      b_rv_q <= gnt_b && !i_b_write;
    end
  end

  assign o_a_gnt    = gnt_a;
  assign o_b_gnt    = gnt_b;
  assign o_a_rvalid = a_rv_q;
  assign o_b_rvalid = b_rv_q;
  assign o_a_rdata  = i_mem_rdata;
  assign o_b_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_cache_mem_arb.sv
// Testbench for cache_mem_arb. It contains a behavioural SRAM and a
// reference model that works from counts of remaining clear cycles, a
// fairness flag and a shadow copy of memory.
module tb_cache_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
  logic [7:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_wd = '0, b_wd = '0;
  logic        ga, gb, rva, rvb, mem_en, mem_we, busy;
  logic [31:0] rda, rdb, mem_wd, mem_rd;
  logic [7:0]  mem_addr;

  cache_mem_arb #(.ADDR_W(8), .DATA_W(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_clear(clear),
    .i_a_req(a_req), .i_a_write(a_wr), .i_a_addr(a_addr), .i_a_wdata(a_wd),
    .i_b_req(b_req), .i_b_write(b_wr), .i_b_addr(b_addr), .i_b_wdata(b_wd),
    .o_a_gnt(ga), .o_b_gnt(gb), .o_a_rvalid(rva), .o_b_rvalid(rvb),
    .o_a_rdata(rda), .o_b_rdata(rdb),
    .o_mem_enable(mem_en), .o_mem_write(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wd), .i_mem_rdata(mem_rd), .o_init_busy(busy)
  );

  always #5 clk = ~clk;

  // behavioural single-port SRAM with registered read data
  logic [31:0] sram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wd;
      else        mem_rd <= sram[mem_addr];
    end
  end

  // reference model
  int          init_left;
  bit          fav_b;
  bit          m_rva, m_rvb, ega, egb;
  logic [31:0] m_rd;
  logic [31:0] shadow [256];

  int n_cmp = 0, n_err = 0;
  logic        s_ga, s_gb, s_rva, s_rvb, s_busy;
  logic [31:0] s_rda, s_rdb;
  logic [7:0]  s_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    init_left = 256;
    fav_b = 1'b0;
    m_rva = 1'b0;
    m_rvb = 1'b0;
  endtask

  task automatic model_check();
    bit ib;
    ib = init_left > 0;
    if (ib)                 begin ega = 0; egb = 0; end
    else if (a_req && b_req) begin ega = !fav_b; egb = fav_b; end
    else                   begin ega = a_req; egb = b_req; end
    chk("grant", {ga, gb}, {ega, egb});
    chk("rvalid", {rva, rvb}, {m_rva, m_rvb});
    chk("busy", busy, ib);
    if (m_rva) chk("a_rdata", rda, m_rd);
    if (m_rvb) chk("b_rdata", rdb, m_rd);
    if (ib)
      chk("init_mem", {mem_en, mem_we, mem_addr, mem_wd}, {1'b1, 1'b1, 8'(256 - init_left), 32'h0});
    else if (ega)
      chk("mem_a", {mem_en, mem_we, mem_addr, mem_wd}, {1'b1, a_wr, a_addr, a_wd});
    else if (egb)
      chk("mem_b", {mem_en, mem_we, mem_addr, mem_wd}, {1'b1, b_wr, b_addr, b_wd});
    else
      chk("mem_idle", {mem_en, mem_we}, 2'b00);
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    m_rva = ega && !a_wr;
    m_rvb = egb && !b_wr;
    if (ega) m_rd = shadow[a_addr];
    if (egb) m_rd = shadow[b_addr];
    if (ega && a_wr) shadow[a_addr] = a_wd;
    if (egb && b_wr) shadow[b_addr] = b_wd;
    if (ega) fav_b = 1'b1;
    if (egb) fav_b = 1'b0;
    if (init_left > 0) begin
      init_left--;
    end else if (clear) begin
      init_left = 256;
      for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_ga = ga; s_gb = gb; s_rva = rva; s_rvb = rvb;
    s_rda = rda; s_rdb = rdb; s_busy = busy; s_addr = mem_addr;
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (s_busy && n < 1000) begin
      n++;
      tick();
    end
  endtask

  typedef struct {
    bit a_req; bit a_wr; logic [7:0] a_addr; logic [31:0] a_wd;
    bit b_req; bit b_wr; logic [7:0] b_addr; logic [31:0] b_wd;
    bit ega; bit egb; bit erva; bit ervb; logic [31:0] erd;
  } vec_t;
  vec_t tbl [11];

  initial begin
    int n;
    tbl[0]  = '{1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0,        1, 0, 0, 0, 32'h0};
    tbl[1]  = '{1, 0, 8'h10, 32'h0,        0, 0, 8'h00, 32'h0,        1, 0, 0, 0, 32'h0};
    tbl[2]  = '{0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        0, 0, 1, 0, 32'hDEADBEEF};
    tbl[3]  = '{0, 0, 8'h00, 32'h0,        1, 1, 8'h20, 32'hCAFEF00D, 0, 1, 0, 0, 32'h0};
    tbl[4]  = '{1, 0, 8'h20, 32'h0,        1, 0, 8'h10, 32'h0,        1, 0, 0, 0, 32'h0};
    tbl[5]  = '{1, 0, 8'h20, 32'h0,        1, 0, 8'h10, 32'h0,        0, 1, 1, 0, 32'hCAFEF00D};
    tbl[6]  = '{1, 0, 8'h10, 32'h0,        1, 0, 8'h20, 32'h0,        1, 0, 0, 1, 32'hDEADBEEF};
    tbl[7]  = '{1, 1, 8'h30, 32'h11111111, 1, 0, 8'h20, 32'h0,        0, 1, 1, 0, 32'hDEADBEEF};
    tbl[8]  = '{1, 1, 8'h30, 32'h11111111, 1, 1, 8'h31, 32'h22222222, 1, 0, 0, 1, 32'hCAFEF00D};
    tbl[9]  = '{0, 0, 8'h00, 32'h0,        1, 1, 8'h31, 32'h22222222, 0, 1, 0, 0, 32'h0};
    tbl[10] = '{0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 32'h0};
    for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
    m_rd = '0;
    model_reset();

    // reset release and the full clear sequence
    tick(); tick();
    rst = 1'b0;
    tick();
    count_busy(n);
    chk("init_len", n, 256);

    // directed read/write and alternating arbitration
    for (int i = 0; i < 11; i++) begin
      a_req = tbl[i].a_req; a_wr = tbl[i].a_wr; a_addr = tbl[i].a_addr; a_wd = tbl[i].a_wd;
      b_req = tbl[i].b_req; b_wr = tbl[i].b_wr; b_addr = tbl[i].b_addr; b_wd = tbl[i].b_wd;
      tick();
      chk($sformatf("tbl%0d_gnt", i), {s_ga, s_gb}, {tbl[i].ega, tbl[i].egb});
      chk($sformatf("tbl%0d_rv", i), {s_rva, s_rvb}, {tbl[i].erva, tbl[i].ervb});
      if (tbl[i].erva) chk($sformatf("tbl%0d_rda", i), s_rda, tbl[i].erd);
      if (tbl[i].ervb) chk($sformatf("tbl%0d_rdb", i), s_rdb, tbl[i].erd);
    end

    // read granted together with a clear pulse; B waits through INIT
    a_req = 1; a_wr = 0; a_addr = 8'h10; clear = 1;
    tick();
    chk("clr_gnt", {s_ga, s_busy}, 2'b10);
    clear = 0; a_req = 0;
    b_req = 1; b_wr = 0; b_addr = 8'h10;
    tick();
    chk("clr_rv", {s_rva, s_busy, s_rda}, {1'b1, 1'b1, 32'hDEADBEEF});
    count_busy(n);
    chk("clr_len", n, 256);
    chk("b_first_run", {s_gb, s_busy}, 2'b10);
    b_req = 0;
    tick();
    chk("cleared_rd", {s_rvb, s_rdb}, {1'b1, 32'h0});

    // reset in the middle of a clear sequence
    clear = 1;
    tick();
    clear = 0;
    a_req = 1; a_wr = 0; a_addr = 8'h05;
    n = 0;
    while (!(s_busy && s_addr == 8'd100) && n < 400) begin
      n++;
      tick();
    end
    chk("reached_100", s_addr, 8'd100);
    rst = 1'b1;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
    count_busy(n);
    chk("rst_init_len", n, 256);
    chk("a_after_rst", s_ga, 1'b1);
    a_req = 0;
    tick();

    // randomized traffic with occasional clears
    for (int c = 0; c < 4000; c++) begin
      if (!a_req && $urandom_range(0, 2) != 0) begin
        a_req = 1; a_wr = 1'($urandom_range(0, 1));
        a_addr = 8'($urandom_range(0, 15)); a_wd = $urandom;
      end
      if (!b_req && $urandom_range(0, 2) != 0) begin
        b_req = 1; b_wr = 1'($urandom_range(0, 1));
        b_addr = 8'($urandom_range(0, 15)); b_wd = $urandom;
      end
      clear = ($urandom_range(0, 299) == 0);
      tick();
      clear = 0;
      if (s_ga) a_req = 0;
      if (s_gb) b_req = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
